extint_gen: RTL
===============

# extint_gen

Parametrised external and pin-change interrupt controller for the AVR-compatible core. It supports up to 8 INTn channels and up to 8 pin-change groups of 8 pins each, with per-channel sense control and a programmable digital noise filter on the INTn paths. It decodes its own registers from the I/O and data-space buses and presents masked IRQ lines plus acknowledge-clear to the core interrupt unit.

## Interface
- N_EXT, 4, number of INTn channels (1..8)
- N_PCG, 4, number of pin-change groups (1..8), 8 pins each
- EICRA_ADDR, 12'h069, sense control channels 0-3 (2 bits each, ISCn at [2n+1:2n])
- EICRB_ADDR, 12'h06A, sense control channels 4-7
- PCICR_ADDR, 12'h068, group enables, bits [N_PCG-1:0]
- PCMSK_BASE, 12'h06B, PCMSKg at PCMSK_BASE+g
- EIFLT_ADDR, 12'h07F, filter length FLT in bits [2:0]
- EIFR_ADDR, 6'h1C; PCIFR_ADDR, 6'h1B; EIMSK_ADDR, 6'h1D (I/O space)
- EXT_IRQ_BASE, 6'h01, vector of INTn = EXT_IRQ_BASE+n
- PC_IRQ_BASE, 6'h05, vector of PCINT group g = PC_IRQ_BASE+g

- cp2  in  1  clock, all logic on rising edge
- ireset  in  1  asynchronous, active-low reset
- IO_Addr  in  6; iore, iowe  in  1  I/O-space access
- ram_Addr  in  12; ramre, ramwe  in  1  data-space access
- dbus_in  in  8; dbus_out  out  8; out_en  out  1  read data / drive enable
- irqack_addr  in  6; irqack  in  1  vector acknowledge
- ext_in  in  N_EXT  raw INTn pins
- pc_in  in  8*N_PCG  raw pin-change pins, group g = bits [8g+7:8g]
- ext_irq  out  N_EXT; pc_irq  out  N_PCG  IRQ requests
- int_en  out  N_EXT (=EIMSK); pcie  out  N_PCG (=PCICR); pcint_en  out  8*N_PCG (=PCMSK concat)

## Operation
- Reset: every register, synchronizer, filter state, warm-up counter = 0; all outputs 0.
- Writable bits: EIMSK[N_EXT-1:0], EICRA/EICRB bits of existing channels, PCICR[N_PCG-1:0], PCMSKg[7:0], EIFLT[2:0]. Other bits read 0. Writes to addresses beyond PCMSK_BASE+N_PCG-1 ignored.
- All inputs pass a 2-flop synchronizer (s).
- Warm-up: 2-bit counter saturates at 3 after reset release; flag sets are suppressed until it reads 3.
- Filter, per INTn channel, filtered level f, 3-bit counter c: FLT=0 -> f=s (combinational). FLT>=1: if s==f then c<=0; else if c==FLT-1 then f<=s, c<=0; else c<=c+1. A pulse shorter than FLT cycles never changes f. Writing EIFLT resets all c to 0.
- Sense (ISCn): 00 low level — EIFR_n never set, ext_irq_n = EIMSK_n & ~f_n; 01 any edge; 10 falling; 11 rising. Edges detected on f vs f_d (f delayed one cycle); edge modes: ext_irq_n = EIFR_n & EIMSK_n.
- Pin change: p_d = s delayed one cycle; group g event = |((s^p_d) & PCMSKg). Sets PCIFR_g. pc_irq_g = PCIFR_g & PCICR_g.
- Flag clear: I/O write of 1 to the bit, or irqack with irqack_addr equal to the channel vector. Set and clear in the same cycle -> flag stays 1 (set wins).
- Mask/sense writes never set or clear flags; flags latch regardless of EIMSK/PCICR.
- Reads combinational: iore with IO address match -> out_en=1, register data; else ramre with data address match -> out_en=1; else out_en=0, dbus_out=0. iore has priority.

## Timing
- Count edges from the first rising cp2 that samples a new pin level as edge 1.
- INTn edge mode: EIFR_n set at edge 3+FLT; ext_irq_n high the same cycle if enabled.
- INTn level mode: ext_irq_n asserts after edge 2+FLT (combinational from f).
- Pin change: PCIFR_g set at edge 3.
- Register writes take effect at the write edge; clear-by-write visible next cycle.
- Reset assertion mid-operation clears all state immediately (async); after release, no flag can set before the 4th cp2 edge.

## Test plan
- ISC0=10, FLT=0, ext_in[0] 1->0, EIMSK=1 -> EIFR[0]=1 and ext_irq[0]=1 at edge 3; irqack with addr 6'h01 -> both 0 next cycle.
- FLT=4, ISC1=11: 3-cycle high pulse on ext_in[1] -> no flag; 6-cycle pulse -> EIFR[1] set at edge 7.
- ISC2=00, EIMSK[2]=1, hold ext_in[2] low 10 cycles -> ext_irq[2] high from after edge 2 until 2 edges after release; EIFR[2] stays 0.
- PCMSK1=8'h04, toggle pc_in[10] -> PCIFR[1] set at edge 3; pc_in[11] toggle -> no flag; PCICR[1]=1 -> pc_irq[1]=1.
- EIFR write 1 to bit 0 in the same cycle as a new qualifying edge -> EIFR[0] remains 1.
- Hold ext_in[0]=0 with ISC0=10 through reset release -> no flag; read EICRA via ramre -> out_en=1, data 8'h00.

Source files
------------

// File: rtl/extint_gen.sv
// extint_gen: INTn and pin-change interrupt controller with noise filter.
// Ports: cp2/ireset clock and async active-low reset; IO_Addr/iore/iowe and
// ram_Addr/ramre/ramwe register buses; dbus_in/dbus_out/out_en read data;
// irqack/irqack_addr vector acknowledge; ext_in/pc_in raw pins;
// ext_irq/pc_irq requests; int_en/pcie/pcint_en register mirrors.
module extint_gen #(
    parameter int          N_EXT        = 4,
    parameter int          N_PCG        = 4,
    parameter logic [11:0] EICRA_ADDR   = 12'h069,
    parameter logic [11:0] EICRB_ADDR   = 12'h06A,
    parameter logic [11:0] PCICR_ADDR   = 12'h068,
    parameter logic [11:0] PCMSK_BASE   = 12'h06B,
    parameter logic [11:0] EIFLT_ADDR   = 12'h07F,
    parameter logic [5:0]  EIFR_ADDR    = 6'h1C,
    parameter logic [5:0]  PCIFR_ADDR   = 6'h1B,
    parameter logic [5:0]  EIMSK_ADDR   = 6'h1D,
    parameter logic [5:0]  EXT_IRQ_BASE = 6'h01,
    parameter logic [5:0]  PC_IRQ_BASE  = 6'h05
) (
    input  logic               cp2,
    input  logic               ireset,
    input  logic [5:0]         IO_Addr,
    input  logic               iore,
    input  logic               iowe,
    input  logic [11:0]        ram_Addr,
    input  logic               ramre,
    input  logic               ramwe,
    input  logic [7:0]         dbus_in,
    output logic [7:0]         dbus_out,
    output logic               out_en,
    input  logic [5:0]         irqack_addr,
    input  logic               irqack,
    input  logic [N_EXT-1:0]   ext_in,
    input  logic [8*N_PCG-1:0] pc_in,
    output logic [N_EXT-1:0]   ext_irq,
    output logic [N_PCG-1:0]   pc_irq,
    output logic [N_EXT-1:0]   int_en,
    output logic [N_PCG-1:0]   pcie,
    output logic [8*N_PCG-1:0] pcint_en
);

    localparam int NP = 8 * N_PCG;

    logic [N_EXT-1:0]   eimsk, eifr, ext_s1, ext_s, f_r, f, f_d;
    logic [N_EXT-1:0]   ext_edge, ext_set, ext_clr;
    logic [2*N_EXT-1:0] isc;
    logic [N_PCG-1:0]   pcicr, pcifr, pc_evt, pc_set, pc_clr;
    logic [NP-1:0]      pcmsk, pc_s1, pc_s, pc_d;
    logic [2:0]         eiflt;
    logic [2:0]         cnt [N_EXT];
    logic [1:0]         wu;
    logic               warm;
    logic [15:0]        isc16, eicr_wd;
    logic               wr_eicra, wr_eicrb, wr_pcicr, wr_eiflt;
    logic               wr_eifr, wr_pcifr, wr_eimsk;
    logic [N_PCG-1:0]   wr_pcmsk;
    logic               io_hit, ram_hit;
    logic [7:0]         io_data, ram_data;

    assign warm     = (wu == 2'd3);
    assign wr_eicra = ramwe && (ram_Addr == EICRA_ADDR);
    assign wr_eicrb = ramwe && (ram_Addr == EICRB_ADDR);
    assign wr_pcicr = ramwe && (ram_Addr == PCICR_ADDR);
    assign wr_eiflt = ramwe && (ram_Addr == EIFLT_ADDR);
    assign wr_eifr  = iowe && (IO_Addr == EIFR_ADDR);
    assign wr_pcifr = iowe && (IO_Addr == PCIFR_ADDR);
    assign wr_eimsk = iowe && (IO_Addr == EIMSK_ADDR);

    // Channel n's sense bits sit at [2n+1:2n] of the doubled write byte,
    // which lands channels 4-7 on the EICRB byte lanes.
    assign eicr_wd = {dbus_in, dbus_in};
    assign isc16   = 16'(isc);

    // With FLT=0 the filter is bypassed; f_r keeps tracking s so a later
    // switch to a nonzero length starts from a consistent state.
    assign f = (eiflt == 3'd0) ? ext_s : f_r;

    always_comb begin
        wr_pcmsk = '0;
        pc_evt   = '0;
        pc_clr   = '0;
        for (int g = 0; g < N_PCG; g++) begin
            wr_pcmsk[g] = ramwe && (ram_Addr == PCMSK_BASE + 12'(g));
            pc_evt[g]   = |((pc_s[8*g+:8] ^ pc_d[8*g+:8]) & pcmsk[8*g+:8]);
            pc_clr[g]   = (wr_pcifr && dbus_in[g]) ||
                          (irqack && (irqack_addr == PC_IRQ_BASE + 6'(g)));
        end
    end

    always_comb begin
        ext_edge = '0;
        ext_clr  = '0;
        ext_irq  = '0;
        for (int n = 0; n < N_EXT; n++) begin
            case (isc[2*n+:2])
                2'b01:   ext_edge[n] = f[n] ^ f_d[n];
                2'b10:   ext_edge[n] = ~f[n] & f_d[n];
                2'b11:   ext_edge[n] = f[n] & ~f_d[n];
                default: ext_edge[n] = 1'b0;
            endcase
            ext_clr[n] = (wr_eifr && dbus_in[n]) ||
                         (irqack && (irqack_addr == EXT_IRQ_BASE + 6'(n)));
            ext_irq[n] = (isc[2*n+:2] == 2'b00) ? (eimsk[n] & ~f[n])
                                                : (eifr[n] & eimsk[n]);
        end
    end

    assign ext_set = ext_edge & {N_EXT{warm}};
    assign pc_set  = pc_evt & {N_PCG{warm}};
    assign pc_irq  = pcifr & pcicr;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            wu     <= '0;
            ext_s1 <= '0;
            ext_s  <= '0;
            pc_s1  <= '0;
            pc_s   <= '0;
            pc_d   <= '0;
            f_r    <= '0;
            f_d    <= '0;
            eimsk  <= '0;
            eifr   <= '0;
            isc    <= '0;
            pcicr  <= '0;
            pcifr  <= '0;
            pcmsk  <= '0;
            eiflt  <= '0;
            for (int n = 0; n < N_EXT; n++) cnt[n] <= '0;
        end else begin
            if (!warm) wu <= wu + 2'd1;
            ext_s1 <= ext_in;
            ext_s  <= ext_s1;
            pc_s1  <= pc_in;
            pc_s   <= pc_s1;
            pc_d   <= pc_s;
            f_d    <= f;
            // Set wins over a simultaneous clear.
            eifr   <= ext_set | (eifr & ~ext_clr);
            pcifr  <= pc_set | (pcifr & ~pc_clr);
            if (wr_eimsk) eimsk <= dbus_in[N_EXT-1:0];
            if (wr_pcicr) pcicr <= dbus_in[N_PCG-1:0];
            if (wr_eiflt) eiflt <= dbus_in[2:0];
            for (int n = 0; n < N_EXT; n++) begin
                if ((n < 4) ? wr_eicra : wr_eicrb)
                    isc[2*n+:2] <= eicr_wd[2*n+:2];
            end
            for (int g = 0; g < N_PCG; g++) begin
                if (wr_pcmsk[g]) pcmsk[8*g+:8] <= dbus_in;
            end
            for (int n = 0; n < N_EXT; n++) begin
                if (wr_eiflt) begin
                    cnt[n] <= '0;
                end else if (eiflt == 3'd0 || ext_s[n] == f_r[n]) begin
                    f_r[n] <= ext_s[n];
                    cnt[n] <= '0;
                end else if (cnt[n] == eiflt - 3'd1) begin
                    f_r[n] <= ext_s[n];
                    cnt[n] <= '0;
                end else begin
                    cnt[n] <= cnt[n] + 3'd1;
                end
            end
        end
    end

    always_comb begin
        io_hit  = 1'b1;
        io_data = '0;
        case (IO_Addr)
            EIFR_ADDR:  io_data = 8'(eifr);
            PCIFR_ADDR: io_data = 8'(pcifr);
            EIMSK_ADDR: io_data = 8'(eimsk);
            default:    io_hit  = 1'b0;
        endcase
    end

    always_comb begin
        ram_hit  = 1'b1;
        ram_data = '0;
        case (ram_Addr)
            EICRA_ADDR: ram_data = isc16[7:0];
            EICRB_ADDR: ram_data = isc16[15:8];
            PCICR_ADDR: ram_data = 8'(pcicr);
            EIFLT_ADDR: ram_data = {5'd0, eiflt};
            default: begin
                ram_hit = 1'b0;
                for (int g = 0; g < N_PCG; g++) begin
                    if (ram_Addr == PCMSK_BASE + 12'(g)) begin
                        ram_hit  = 1'b1;
                        ram_data = pcmsk[8*g+:8];
                    end
                end
            end
        endcase
    end

    always_comb begin
        out_en   = 1'b0;
        dbus_out = '0;
        if (iore && io_hit) begin
            out_en   = 1'b1;
            dbus_out = io_data;
        end else if (ramre && ram_hit) begin
            out_en   = 1'b1;
            dbus_out = ram_data;
        end
    end

    assign int_en   = eimsk;
    assign pcie     = pcicr;
    assign pcint_en = pcmsk;

endmodule
